// File: rtl/production_line_pkg.sv
// Shared stage encoding, default dwell times and monitor states for productionLine and its monitor.
package production_line_pkg;

  typedef enum logic [1:0] {
    SetupS   = 2'b00,
    ProcessS = 2'b01,
    PackS    = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    SYNC  = 2'b00,
    TRACK = 2'b01,
    FAULT = 2'b10
  } mon_state_e;

  localparam logic [1:0] STAGE_ILLEGAL = 2'b11;

  localparam int DEF_SETUP_CYCLES   = 101;
  localparam int DEF_PROCESS_CYCLES = 201;
  localparam int DEF_PACK_CYCLES    = 51;

  // Only the forward cycle Setup -> Process -> Pack -> Setup is a legal step.
  function automatic logic is_legal_step(input logic [1:0] from_stage, input logic [1:0] to_stage);
    return (from_stage == SetupS   && to_stage == ProcessS) ||
           (from_stage == ProcessS && to_stage == PackS)    ||
           (from_stage == PackS    && to_stage == SetupS);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/line_dwell_timer.sv
// Registers the stage bus once and counts how many cycles the registered stage has been held.
module line_dwell_timer
  import production_line_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       stage,
  output logic [1:0]       stage_q,
  output logic             stage_edge,
  output logic [CNT_W-1:0] dwell
);

  assign stage_edge = (stage != stage_q);

  // dwell restarts at 1 so that it equals the number of cycles stage_q holds a value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_q <= SetupS;
      dwell   <= '0;
    end else begin
      stage_q <= stage;
      if (stage_edge)
        dwell <= CNT_W'(1);
      else if (dwell != '1)
        dwell <= dwell + 1'b1;
    end
  end

endmodule

// File: rtl/production_line_monitor.sv
// Checks stage order and dwell of the productionLine stage bus and counts finished units.
// Optional stuck-stage watchdog is built only when MON_WATCHDOG_EN is defined.
//
// state | meaning
// SYNC  | waiting for an edge into Setup; partial dwell after reset/clear is ignored
// TRACK | checking every edge for order and dwell, counting units
// FAULT | sequence or watchdog fault seen; outputs frozen until clear or reset
module production_line_monitor
  import production_line_pkg::*;
#(
  parameter int SETUP_CYCLES   = DEF_SETUP_CYCLES,
  parameter int PROCESS_CYCLES = DEF_PROCESS_CYCLES,
  parameter int PACK_CYCLES    = DEF_PACK_CYCLES,
  parameter int TOL            = 0,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       stage,
  input  logic             clear,
  output logic             unit_done,
  output logic [CNT_W-1:0] unit_count,
  output logic             seq_err,
  output logic             time_err,
  output logic             stuck_err,
  output logic             in_sync
);

  localparam logic [CNT_W:0] TOL_W = (CNT_W+1)'(TOL);

  logic [1:0]       stage_q;
  logic             stage_edge;
  logic [CNT_W-1:0] dwell;
  logic [CNT_W-1:0] req;
  logic             dwell_ok;
  logic             wd_trip;
  mon_state_e       mon_state;

  line_dwell_timer #(.CNT_W(CNT_W)) u_dwell (
    .clk        (clk),
    .reset      (reset),
    .stage      (stage),
    .stage_q    (stage_q),
    .stage_edge (stage_edge),
    .dwell      (dwell)
  );

  always_comb begin
    req = CNT_W'(SETUP_CYCLES);
    case (stage_q)
      ProcessS: req = CNT_W'(PROCESS_CYCLES);
      PackS:    req = CNT_W'(PACK_CYCLES);
      default:  req = CNT_W'(SETUP_CYCLES);
    endcase
  end

  // One extra bit keeps req+TOL and dwell+TOL from wrapping.
  assign dwell_ok = ({1'b0, dwell} + TOL_W >= {1'b0, req}) &&
                    ({1'b0, dwell} <= {1'b0, req} + TOL_W);

  assign in_sync = (mon_state == TRACK);

`ifdef MON_WATCHDOG_EN
  localparam int WD_LIMIT = max3(SETUP_CYCLES, PROCESS_CYCLES, PACK_CYCLES) + TOL + 1;

  // Trips on the edge where dwell becomes WD_LIMIT without the stage having moved.
  assign wd_trip = (mon_state == TRACK) && !stage_edge && (dwell >= CNT_W'(WD_LIMIT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stuck_err <= 1'b0;
    else if (clear)
      stuck_err <= 1'b0;
    else if (wd_trip && stage != STAGE_ILLEGAL)
      stuck_err <= 1'b1;
  end
`else
  assign wd_trip   = 1'b0;
  assign stuck_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mon_state  <= SYNC;
      unit_done  <= 1'b0;
      unit_count <= '0;
      seq_err    <= 1'b0;
      time_err   <= 1'b0;
    end else begin
      unit_done <= 1'b0;
      if (clear) begin
        mon_state  <= SYNC;
        unit_count <= '0;
        seq_err    <= 1'b0;
        time_err   <= 1'b0;
      end else begin
        case (mon_state)
          SYNC: begin
            if (stage == STAGE_ILLEGAL) begin
              seq_err   <= 1'b1;
              mon_state <= FAULT;
            end else if (stage_edge && stage == SetupS) begin
              mon_state <= TRACK;
            end
          end
          TRACK: begin
            if (stage_edge && !dwell_ok)
              time_err <= 1'b1;
            if (stage == STAGE_ILLEGAL || (stage_edge && !is_legal_step(stage_q, stage))) begin
              seq_err   <= 1'b1;
              mon_state <= FAULT;
            end else if (stage_edge && stage_q == PackS && dwell_ok) begin
              unit_done <= 1'b1;
              if (unit_count != '1)
                unit_count <= unit_count + 1'b1;
            end else if (wd_trip) begin
              mon_state <= FAULT;
            end
          end
          default: mon_state <= FAULT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_production_line_monitor.sv
// Scoreboard bench for production_line_monitor: expected unit counts are queued when a good
// Pack->Setup edge is driven and compared when unit_done pulses.
module tb_production_line_monitor;
  import production_line_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  stage;
  logic        clear;
  logic        unit_done;
  logic [15:0] unit_count;
  logic        seq_err, time_err, stuck_err, in_sync;

  int errors = 0;
  int checks = 0;
  int exp_count = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_v;

  production_line_monitor dut (
    .clk        (clk),
    .reset      (reset),
    .stage      (stage),
    .clear      (clear),
    .unit_done  (unit_done),
    .unit_count (unit_count),
    .seq_err    (seq_err),
    .time_err   (time_err),
    .stuck_err  (stuck_err),
    .in_sync    (in_sync)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  always @(negedge clk) begin
    if (reset === 1'b1 && unit_done === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unit_done_unexpected: pulse seen with unit_count=%0d, expected no pulse", unit_count);
      end else begin
        exp_v = exp_q.pop_front();
        if (unit_count !== exp_v) begin
          errors++;
          $display("FAIL unit_count_on_pulse: got %0d, expected %0d", unit_count, exp_v);
        end
      end
    end
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sync_line();
    stage = PackS;
    hold(3);
    stage = SetupS;
  endtask

  task automatic good_unit();
    hold(101);
    stage = ProcessS;
    hold(201);
    stage = PackS;
    hold(51);
    stage = SetupS;
    exp_count++;
    exp_q.push_back(16'(exp_count));
  endtask

  task automatic do_clear();
    clear = 1'b1;
    hold(1);
    clear = 1'b0;
    exp_count = 0;
    checks++;
    if ({seq_err, time_err, stuck_err, in_sync} !== 4'b0000 || unit_count !== 16'd0) begin
      errors++;
      $display("FAIL clear: got seq=%b time=%b stuck=%b sync=%b count=%0d, expected all 0",
               seq_err, time_err, stuck_err, in_sync, unit_count);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; stage = SetupS; clear = 1'b0;
    hold(3);
    checks++;
    if ({unit_done, seq_err, time_err, stuck_err, in_sync} !== 5'b0 || unit_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: got done=%b seq=%b time=%b stuck=%b sync=%b count=%0d, expected all 0",
               unit_done, seq_err, time_err, stuck_err, in_sync, unit_count);
    end
    reset = 1'b1;
    hold(2);
  endtask

  task automatic test_normal_units();
    sync_line();
    hold(1);
    checks++;
    if (in_sync !== 1'b1) begin
      errors++; $display("FAIL sync_entry: in_sync got %b, expected 1", in_sync);
    end
    stage = SetupS;
    hold(100);
    stage = ProcessS; hold(201); stage = PackS; hold(51); stage = SetupS;
    exp_count++; exp_q.push_back(16'(exp_count));
    good_unit();
    good_unit();
    hold(2);
    checks++;
    if (unit_count !== 16'd3 || {seq_err, time_err, stuck_err} !== 3'b000 || in_sync !== 1'b1) begin
      errors++;
      $display("FAIL three_units: got count=%0d seq=%b time=%b stuck=%b sync=%b, expected 3,0,0,0,1",
               unit_count, seq_err, time_err, stuck_err, in_sync);
    end
  endtask

  task automatic test_short_dwell();
    hold(99);
    stage = ProcessS;
    hold(195);
    stage = PackS;
    hold(1);
    checks++;
    if (time_err !== 1'b1 || seq_err !== 1'b0 || unit_done !== 1'b0 || in_sync !== 1'b1) begin
      errors++;
      $display("FAIL short_process: got time=%b seq=%b done=%b sync=%b, expected 1,0,0,1",
               time_err, seq_err, unit_done, in_sync);
    end
    hold(39);
    stage = SetupS;
    hold(2);
    checks++;
    if (unit_count !== 16'd3 || time_err !== 1'b1) begin
      errors++;
      $display("FAIL short_pack_no_count: got count=%0d time=%b, expected 3,1", unit_count, time_err);
    end
    do_clear();
  endtask

  task automatic test_bad_order();
    sync_line();
    good_unit();
    hold(101);
    stage = PackS;
    hold(1);
    checks++;
    if (seq_err !== 1'b1 || time_err !== 1'b0 || in_sync !== 1'b0) begin
      errors++;
      $display("FAIL setup_to_pack: got seq=%b time=%b sync=%b, expected 1,0,0", seq_err, time_err, in_sync);
    end
    hold(50);
    stage = SetupS;
    hold(3);
    checks++;
    if (unit_count !== 16'd1 || seq_err !== 1'b1) begin
      errors++;
      $display("FAIL fault_frozen: got count=%0d seq=%b, expected 1,1", unit_count, seq_err);
    end
    do_clear();
  endtask

  task automatic test_illegal_code();
    sync_line();
    hold(50);
    stage = STAGE_ILLEGAL;
    hold(1);
    stage = SetupS;
    checks++;
    if (seq_err !== 1'b1 || time_err !== 1'b1 || in_sync !== 1'b0) begin
      errors++;
      $display("FAIL illegal_in_track: got seq=%b time=%b sync=%b, expected 1,1,0", seq_err, time_err, in_sync);
    end
    hold(2);
    do_clear();
    stage = STAGE_ILLEGAL;
    hold(1);
    stage = SetupS;
    checks++;
    if (seq_err !== 1'b1 || time_err !== 1'b0 || in_sync !== 1'b0) begin
      errors++;
      $display("FAIL illegal_in_sync: got seq=%b time=%b sync=%b, expected 1,0,0", seq_err, time_err, in_sync);
    end
    hold(1);
    do_clear();
  endtask

  task automatic test_dwell_boundary();
    int lens[2] = '{100, 102};
    foreach (lens[i]) begin
      sync_line();
      hold(lens[i]);
      stage = ProcessS;
      hold(1);
      checks++;
      if (time_err !== 1'b1 || seq_err !== 1'b0 || in_sync !== 1'b1) begin
        errors++;
        $display("FAIL setup_dwell_%0d: got time=%b seq=%b sync=%b, expected 1,0,1",
                 lens[i], time_err, seq_err, in_sync);
      end
      do_clear();
    end
  endtask

  task automatic test_reset_mid_stage();
    sync_line();
    good_unit();
    hold(101);
    stage = ProcessS;
    hold(80);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({unit_done, seq_err, time_err, stuck_err, in_sync} !== 5'b0 || unit_count !== 16'd0) begin
      errors++;
      $display("FAIL async_reset: got done=%b seq=%b time=%b stuck=%b sync=%b count=%0d, expected all 0",
               unit_done, seq_err, time_err, stuck_err, in_sync, unit_count);
    end
    exp_count = 0;
    hold(2);
    reset = 1'b1;
    hold(50);
    stage = PackS;
    hold(51);
    checks++;
    if (in_sync !== 1'b0 || seq_err !== 1'b0 || time_err !== 1'b0) begin
      errors++;
      $display("FAIL partial_unchecked: got sync=%b seq=%b time=%b, expected 0,0,0", in_sync, seq_err, time_err);
    end
    stage = SetupS;
    hold(1);
    checks++;
    if (in_sync !== 1'b1) begin
      errors++; $display("FAIL resync_after_reset: in_sync got %b, expected 1", in_sync);
    end
    hold(100);
    stage = ProcessS; hold(201); stage = PackS; hold(51); stage = SetupS;
    exp_count++; exp_q.push_back(16'(exp_count));
    hold(2);
    checks++;
    if (unit_count !== 16'd1) begin
      errors++; $display("FAIL count_after_reset: got %0d, expected 1", unit_count);
    end
  endtask

  task automatic test_hung_stage();
    hold(298);
    checks++;
`ifdef MON_WATCHDOG_EN
    if (stuck_err !== 1'b1 || in_sync !== 1'b0) begin
      errors++; $display("FAIL watchdog_trip: got stuck=%b sync=%b, expected 1,0", stuck_err, in_sync);
    end
`else
    if (stuck_err !== 1'b0 || time_err !== 1'b0) begin
      errors++; $display("FAIL no_watchdog_hold: got stuck=%b time=%b, expected 0,0", stuck_err, time_err);
    end
`endif
    stage = ProcessS;
    hold(1);
    checks++;
`ifdef MON_WATCHDOG_EN
    if (stuck_err !== 1'b1 || time_err !== 1'b0 || in_sync !== 1'b0) begin
      errors++;
      $display("FAIL watchdog_after_edge: got stuck=%b time=%b sync=%b, expected 1,0,0", stuck_err, time_err, in_sync);
    end
`else
    if (stuck_err !== 1'b0 || time_err !== 1'b1 || seq_err !== 1'b0 || in_sync !== 1'b1) begin
      errors++;
      $display("FAIL hung_setup_edge: got stuck=%b time=%b seq=%b sync=%b, expected 0,1,0,1",
               stuck_err, time_err, seq_err, in_sync);
    end
`endif
  endtask

  initial begin
    reset = 1'b0; stage = SetupS; clear = 1'b0;
    test_reset();
    test_normal_units();
    test_short_dwell();
    test_bad_order();
    test_illegal_code();
    test_dwell_boundary();
    test_reset_mid_stage();
    test_hung_stage();
    hold(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_pulses: %0d expected unit_done pulses never seen, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
